// File: rtl/ff_pkg.sv
// rtl/ff_pkg.sv - shared mode and SR policy constants for the flip-flop bank
package ff_pkg;

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } ff_mode_e;

    localparam logic [1:0] SR_HOLD  = 2'd0;
    localparam logic [1:0] SR_SET   = 2'd1;
    localparam logic [1:0] SR_RESET = 2'd2;

endpackage

// File: rtl/ff_cell.sv
// rtl/ff_cell.sv - single-bit next-state logic for SR/JK/D/T operation
module ff_cell
    import ff_pkg::*;
(
    input  logic       q,
    input  logic       a,
    input  logic       b,
    input  logic [1:0] mode,
    input  logic [1:0] policy,
    output logic       nxt
);

    always_comb begin
        nxt = q;
        case (mode)
            MODE_SR: begin
                case ({a, b})
                    2'b10:   nxt = 1'b1;
                    2'b01:   nxt = 1'b0;
                    // S=R=1 resolves by policy; any unknown policy code holds
                    2'b11:   nxt = (policy == SR_SET)   ? 1'b1 :
                                   (policy == SR_RESET) ? 1'b0 : q;
                    default: nxt = q;
                endcase
            end
            MODE_JK: begin
                case ({a, b})
                    2'b10:   nxt = 1'b1;
                    2'b01:   nxt = 1'b0;
                    2'b11:   nxt = ~q;
                    default: nxt = q;
                endcase
            end
            MODE_D:  nxt = a;
            MODE_T:  nxt = q ^ a;
            default: nxt = q;
        endcase
    end

endmodule

// File: rtl/ff_bank_multimode.sv
// rtl/ff_bank_multimode.sv - WIDTH-bit multimode flip-flop bank with load and S=R=1 tracking
module ff_bank_multimode
    import ff_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               SR_POLICY   = 0,
    parameter int               ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     qb,
    output logic                 illegal,
    output logic [ERR_CNT_W-1:0] illegal_cnt
);

    localparam logic [1:0]           POLICY  = SR_POLICY[1:0];
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] nxt;
    logic             event_hit;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_cell u_cell (
            .q      (q[i]),
            .a      (a[i]),
            .b      (b[i]),
            .mode   (mode),
            .policy (POLICY),
            .nxt    (nxt[i])
        );
    end

    // One event per cycle no matter how many bits see S=R=1
    assign event_hit = (mode == MODE_SR) && en && !load && (|(a & b));

    always_ff @(posedge clk) begin
        if (!rst) begin
            q           <= RESET_VALUE;
            illegal     <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            if (load) begin
                q <= load_val;
            end else if (en) begin
                q <= nxt;
            end

            // A same-cycle event overrides clr_err and restarts the count at one
            if (event_hit) begin
                illegal <= 1'b1;
                if (clr_err) begin
                    illegal_cnt <= CNT_ONE;
                end else if (illegal_cnt != '1) begin
                    illegal_cnt <= illegal_cnt + CNT_ONE;
                end
            end else if (clr_err) begin
                illegal     <= 1'b0;
                illegal_cnt <= '0;
            end
        end
    end

    assign qb = ~q;

endmodule

// File: tb/tb_ff_bank_multimode.sv
// tb/tb_ff_bank_multimode.sv - directed self-checking bench for ff_bank_multimode
module tb_ff_bank_multimode;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       load;
    logic [7:0] load_val;
    logic       clr_err;

    logic [7:0] q_h, qb_h, q_s, qb_s, q_r, qb_r;
    logic       ill_h, ill_s, ill_r;
    logic [7:0] cnt_h, cnt_s;
    logic [1:0] cnt_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // hold policy, non-zero reset value
    ff_bank_multimode #(.WIDTH(8), .RESET_VALUE(8'h81), .SR_POLICY(0), .ERR_CNT_W(8)) u_hold (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .load(load),
        .load_val(load_val), .clr_err(clr_err), .q(q_h), .qb(qb_h),
        .illegal(ill_h), .illegal_cnt(cnt_h)
    );

    ff_bank_multimode #(.WIDTH(8), .RESET_VALUE(8'h00), .SR_POLICY(1), .ERR_CNT_W(8)) u_set (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .load(load),
        .load_val(load_val), .clr_err(clr_err), .q(q_s), .qb(qb_s),
        .illegal(ill_s), .illegal_cnt(cnt_s)
    );

    // reset-wins policy with a 2-bit counter to exercise saturation
    ff_bank_multimode #(.WIDTH(8), .RESET_VALUE(8'h00), .SR_POLICY(2), .ERR_CNT_W(2)) u_rst (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .load(load),
        .load_val(load_val), .clr_err(clr_err), .q(q_r), .qb(qb_r),
        .illegal(ill_r), .illegal_cnt(cnt_r)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; load_val = v;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; mode = 2'b11; a = 8'hFF; b = 8'hFF;
        load = 1'b1; load_val = 8'h55; clr_err = 1'b0;
        tick();
        checks++; if (q_h !== 8'h81) begin errors++; $display("FAIL reset_q_hold got %h want 81", q_h); end
        checks++; if (qb_h !== 8'h7E) begin errors++; $display("FAIL reset_qb_hold got %h want 7e", qb_h); end
        checks++; if (q_s !== 8'h00 || q_r !== 8'h00) begin errors++; $display("FAIL reset_q_others got %h/%h want 00/00", q_s, q_r); end
        checks++; if ({ill_h, ill_s, ill_r} !== 3'b000 || cnt_h !== 8'd0 || cnt_s !== 8'd0 || cnt_r !== 2'd0) begin
            errors++; $display("FAIL reset_err got ill=%b cnt=%0d/%0d/%0d want 000 0/0/0", {ill_h, ill_s, ill_r}, cnt_h, cnt_s, cnt_r);
        end
        rst = 1'b1; load = 1'b0; a = 8'h00; b = 8'h00; mode = 2'b00;
    endtask

    task automatic test_sr_sequence();
        logic [7:0] seq;
        seq = 8'b0011_0101;
        en = 1'b1; mode = 2'b00;
        for (int i = 0; i < 8; i++) begin
            a = {7'b0, seq[i]};
            b = {7'b0, ~seq[i]};
            tick();
            checks++; if (q_s[0] !== seq[i] || qb_s[0] !== ~seq[i]) begin
                errors++; $display("FAIL sr_seq step %0d got q0=%b qb0=%b want %b/%b", i, q_s[0], qb_s[0], seq[i], ~seq[i]);
            end
            checks++; if (q_h !== {7'b1000000, seq[i]} || ill_h !== 1'b0) begin
                errors++; $display("FAIL sr_seq_hold step %0d got q=%h ill=%b want %h 0", i, q_h, ill_h, {7'b1000000, seq[i]});
            end
        end
        a = 8'h00; b = 8'h00;
    endtask

    task automatic test_sr_illegal();
        clr_err = 1'b1;
        do_load(8'h0F);
        clr_err = 1'b0; en = 1'b1; mode = 2'b00; a = 8'hFF; b = 8'hFF;
        repeat (3) tick();
        checks++; if (q_h !== 8'h0F) begin errors++; $display("FAIL sr11_hold got %h want 0f", q_h); end
        checks++; if (q_s !== 8'hFF) begin errors++; $display("FAIL sr11_set got %h want ff", q_s); end
        checks++; if (q_r !== 8'h00) begin errors++; $display("FAIL sr11_reset got %h want 00", q_r); end
        checks++; if ({ill_h, ill_s, ill_r} !== 3'b111 || cnt_h !== 8'd3 || cnt_s !== 8'd3 || cnt_r !== 2'd3) begin
            errors++; $display("FAIL sr11_err got ill=%b cnt=%0d/%0d/%0d want 111 3/3/3", {ill_h, ill_s, ill_r}, cnt_h, cnt_s, cnt_r);
        end
        repeat (2) tick();
        checks++; if (cnt_r !== 2'd3 || cnt_h !== 8'd5) begin
            errors++; $display("FAIL cnt_saturate got %0d/%0d want 3/5", cnt_r, cnt_h);
        end
        clr_err = 1'b1;
        tick();
        checks++; if (cnt_r !== 2'd1 || cnt_h !== 8'd1 || ill_r !== 1'b1 || ill_h !== 1'b1) begin
            errors++; $display("FAIL clr_with_event got cnt=%0d/%0d ill=%b%b want 1/1 11", cnt_r, cnt_h, ill_r, ill_h);
        end
        a = 8'h00; b = 8'h00;
        tick();
        checks++; if (cnt_r !== 2'd0 || cnt_h !== 8'd0 || ill_r !== 1'b0 || ill_h !== 1'b0) begin
            errors++; $display("FAIL clr_alone got cnt=%0d/%0d ill=%b%b want 0/0 00", cnt_r, cnt_h, ill_r, ill_h);
        end
        clr_err = 1'b0;
    endtask

    task automatic test_jk_t_d();
        logic [7:0] exp_jk [3];
        logic [7:0] exp_t  [3];
        exp_jk = '{8'h5A, 8'hA5, 8'h5A};
        exp_t  = '{8'hA4, 8'hA5, 8'hA4};
        do_load(8'hA5);
        mode = 2'b01; a = 8'hFF; b = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (q_h !== exp_jk[i]) begin errors++; $display("FAIL jk_toggle step %0d got %h want %h", i, q_h, exp_jk[i]); end
        end
        checks++; if (ill_h !== 1'b0 || cnt_h !== 8'd0) begin errors++; $display("FAIL jk_no_illegal got %b %0d want 0 0", ill_h, cnt_h); end
        do_load(8'hA5);
        mode = 2'b11; a = 8'h01; b = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (q_s !== exp_t[i]) begin errors++; $display("FAIL t_toggle step %0d got %h want %h", i, q_s, exp_t[i]); end
        end
        mode = 2'b10; a = 8'h3C;
        tick();
        checks++; if (q_r !== 8'h3C || qb_r !== 8'hC3) begin errors++; $display("FAIL d_mode got %h/%h want 3c/c3", q_r, qb_r); end
        en = 1'b0; a = 8'h00;
        tick();
        checks++; if (q_r !== 8'h3C) begin errors++; $display("FAIL en_hold got %h want 3c", q_r); end
    endtask

    task automatic test_load_priority();
        en = 1'b0; mode = 2'b00; a = 8'hFF; b = 8'hFF;
        do_load(8'h96);
        checks++; if (q_h !== 8'h96 || q_s !== 8'h96 || q_r !== 8'h96) begin
            errors++; $display("FAIL load got %h/%h/%h want 96", q_h, q_s, q_r);
        end
        checks++; if ({ill_h, ill_s, ill_r} !== 3'b000 || cnt_h !== 8'd0) begin
            errors++; $display("FAIL load_no_illegal got ill=%b cnt=%0d want 000 0", {ill_h, ill_s, ill_r}, cnt_h);
        end
    endtask

    task automatic test_mid_reset();
        en = 1'b1; mode = 2'b00; a = 8'hFF; b = 8'hFF;
        tick();
        checks++; if (q_h !== 8'h96 || q_s !== 8'hFF || cnt_h !== 8'd1) begin
            errors++; $display("FAIL pre_reset_sr got %h/%h cnt=%0d want 96/ff 1", q_h, q_s, cnt_h);
        end
        mode = 2'b11;
        tick();
        checks++; if (q_h !== 8'h69 || q_s !== 8'h00) begin errors++; $display("FAIL pre_reset_t got %h/%h want 69/00", q_h, q_s); end
        rst = 1'b0; load = 1'b1; load_val = 8'h55;
        tick();
        checks++; if (q_h !== 8'h81 || ill_h !== 1'b0 || cnt_h !== 8'd0 || q_s !== 8'h00) begin
            errors++; $display("FAIL mid_reset got q=%h ill=%b cnt=%0d qs=%h want 81 0 0 00", q_h, ill_h, cnt_h, q_s);
        end
        rst = 1'b1; load = 1'b0;
        tick();
        checks++; if (q_h !== 8'h7E || q_s !== 8'hFF) begin errors++; $display("FAIL post_reset_t got %h/%h want 7e/ff", q_h, q_s); end
    endtask

    initial begin
        test_reset();
        test_sr_sequence();
        test_sr_illegal();
        test_jk_t_d();
        test_load_priority();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ff_bank_multimode.md
# ff_bank_multimode

Parametrised bank of WIDTH independent flip-flops sharing one clock, each bit behaving as an SR, JK, D or T flip-flop according to a run-time mode select. It is the generalised successor of the single-bit SR flip-flop: it adds width, run-time mode selection, a parallel load, a defined policy for the S=R=1 condition, and a sticky error flag with a saturating error counter. It is the storage primitive for the flip-flop library and its benches.

## Interface
- WIDTH, 8: number of flip-flop bits.
- RESET_VALUE, 0 (WIDTH bits): q value after reset.
- SR_POLICY, 0: handling of S=R=1 in SR mode. 0 = hold; 1 = set wins; 2 = reset wins.
- ERR_CNT_W, 8: width of the illegal-event counter.

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-low reset.
- en  in  1  update enable. When 0, q holds.
- mode  in  2  per-bank function. 00 SR, 01 JK, 10 D, 11 T.
- a  in  WIDTH  S / J / D / T input, per bit.
- b  in  WIDTH  R / K input, per bit. Ignored in D and T modes.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value for parallel load.
- clr_err  in  1  clears illegal and illegal_cnt.
- q  out  WIDTH  state.
- qb  out  WIDTH  always ~q (combinational from q).
- illegal  out  1  sticky. Set by any S=R=1 event.
- illegal_cnt  out  ERR_CNT_W  count of S=R=1 cycles. Saturates.

## Operation
- Priority at each rising edge: rst=0, then load=1, then en=1, then hold.
- rst=0: q=RESET_VALUE, illegal=0, illegal_cnt=0. All other inputs are ignored.
- load=1: q=load_val. This applies regardless of en and mode. No illegal detection occurs.
- en=1, load=0: each bit i updates from q[i], a[i] and b[i]:
  - SR: 00 hold; 10 set; 01 clear; 11 per SR_POLICY.
  - JK: 00 hold; 10 set; 01 clear; 11 toggle.
  - D: q[i]=a[i].
  - T: q[i]=q[i]^a[i].
- Illegal event: mode=SR, en=1, load=0, rst=1, and (a&b)!=0.
  - One event per cycle, however many bits are affected.
  - The event sets illegal and increments illegal_cnt.
  - illegal_cnt saturates at 2^ERR_CNT_W-1.
  - The event is flagged under every SR_POLICY.
- clr_err=1 with no event in the same cycle: illegal=0, illegal_cnt=0.
- clr_err=1 with an event in the same cycle: the event wins. illegal=1, illegal_cnt=1.
- A mode change takes effect at the same edge at which it is sampled. No state is lost on a mode change.

## Timing
- Latency is 1 cycle. Inputs sampled at edge k appear on q immediately after edge k.
- qb tracks q with zero cycles of latency.
- illegal and illegal_cnt update at the same edge as q.
- Reset takes effect at the first edge with rst=0, including mid-sequence. The first update after release is at the first edge with rst=1.
- Outputs after reset: q=RESET_VALUE, qb=~RESET_VALUE, illegal=0, illegal_cnt=0.
- There are no combinational paths from inputs to outputs.

## Structure
- Shared package ff_pkg holds:
  - mode constants: MODE_SR, MODE_JK, MODE_D, MODE_T;
  - SR_POLICY constants: SR_HOLD, SR_SET, SR_RESET.
- Sub-module ff_cell contains the single-bit next-state logic. Inputs: q, a, b, mode, policy. Output: next state.
  - The bank instantiates WIDTH copies of ff_cell in a generate loop.
  - Error detection, the counter, load and reset sit in the bank module.

## Test plan
- Reset, then SR mode, en=1, WIDTH=8. Drive bit 0 through the sequence 1,0,1,0,1,1,0,0 on a[0], with b[0]=~a[0], one value per cycle. Required: q[0] follows each value one cycle later, qb[0]=~q[0], illegal stays 0.
- SR mode, q=8'h0F, a=b=8'hFF, held for 3 cycles. Required:
  - SR_POLICY=0: q stays 8'h0F.
  - SR_POLICY=1: q=8'hFF.
  - SR_POLICY=2: q=8'h00.
  - In all three: illegal=1 and illegal_cnt=3.
- JK mode, q=8'hA5, a=b=8'hFF. Required: q=8'h5A, then 8'hA5 on alternate cycles. T mode with a=8'h01 gives the same alternation on bit 0 only. D mode with a=8'h3C gives q=8'h3C.
- ERR_CNT_W=2: 5 consecutive illegal cycles leave illegal_cnt=3 (saturated). Then clr_err=1 together with an illegal event gives illegal_cnt=1, illegal=1. Then clr_err alone gives 0 and 0.
- load=1 with load_val=8'h96, en=0, mode=SR, a=b=8'hFF. Required: q=8'h96 and no illegal event.
- rst=0 asserted mid-sequence in T mode, with RESET_VALUE=8'h81 and load=1 in the same cycle. Required: q=8'h81, illegal=0, illegal_cnt=0 at that edge. Normal updates resume at the first edge after rst returns to 1.
